manch_tx_ctrl: RTL and testbench

Frame sequencer for the Manchester transmit path. It accepts bytes on a valid/ready stream and generates its own half-bit timing. Each frame is serialised as a preamble, an SFD byte, the payload bytes (LSB first) and an inter-frame gap. The line output uses the same convention as the existing encoder: `tx_manch = bit XOR phase`, with phase 0 in the first half-bit and 1 in the second. This block sits between the packet source and the line driver and replaces free-running encoder timing with frame-aware sequencing.

---
 rtl/manch_tx_ctrl_if.sv | 16 +
 rtl/manch_tx_ctrl.sv | 145 ++++++++++++++
 tb/tb_manch_tx_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/manch_tx_ctrl_if.sv
// manch_tx_ctrl_if
// Byte stream feeding the Manchester frame sequencer.
//   s_data  : payload byte
//   s_valid : s_data/s_last valid
//   s_last  : final byte of the frame
//   s_ready : byte accepted on s_valid & s_ready at a rising clk edge
// master = packet source, slave = manch_tx_ctrl.
interface manch_tx_ctrl_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/manch_tx_ctrl.sv
// manch_tx_ctrl
// Frame sequencer for the Manchester transmit path. Each frame goes out as
// preamble (1,0,1,0...), SFD byte, payload bytes LSB first, then an idle gap.
// Line coding: tx_manch = bit ^ phase (phase 0 = first half-bit).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   s        : byte stream (manch_tx_ctrl_if.slave)
//   tx_manch : Manchester line output (registered)
//   tx_en    : line-driver enable (registered)
//   busy     : not IDLE (registered)
//   underrun : one-cycle pulse when a frame is cut short for lack of data
// Build option: define MANCH_TX_PARITY_EN to append an even-parity bit after
// every payload byte.
module manch_tx_ctrl #(
  parameter int         CLK_FREQ      = 18_750_000,
  parameter int         BIT_RATE      = 115200,
  parameter int         PREAMBLE_BITS = 8,
  parameter logic [7:0] SFD           = 8'hD5,
  parameter int         GAP_BITS      = 2
) (
  input  logic           clk,
  input  logic           rst,
  manch_tx_ctrl_if.slave s,
  output logic           tx_manch,
  output logic           tx_en,
  output logic           busy,
  output logic           underrun
);
  localparam int HALF = CLK_FREQ / (2 * BIT_RATE);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int MAXB = (PREAMBLE_BITS > 8) ?
                        ((PREAMBLE_BITS > GAP_BITS) ? PREAMBLE_BITS : GAP_BITS) :
                        ((GAP_BITS > 8) ? GAP_BITS : 8);
  localparam int BW   = $clog2(MAXB);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_GAP
`ifdef MANCH_TX_PARITY_EN
    , S_PAR
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            phase;
  logic [BW-1:0]   bit_idx;
  logic [7:0]      hold_data, shreg;
  logic            hold_last;
  logic            rdy_en;    // holds s_ready low for the first cycle after reset
  logic            active, tx_state, wrap, bit_end, last_end, accept_next, restart, cur_bit;

  assign active   = (state != S_IDLE);
  assign tx_state = active && (state != S_GAP);
  assign wrap     = active && (cnt == CW'(HALF - 1));
  assign bit_end  = wrap && phase;

  // Final cycle of the last bit belonging to a payload byte: NEXT decision point.
`ifdef MANCH_TX_PARITY_EN
  assign last_end = bit_end && (state == S_PAR);
`else
  assign last_end = bit_end && (state == S_DATA) && (bit_idx == BW'(7));
`endif

  // Decode of state/timer only; never looks at s_valid.
  assign s.s_ready   = ((state == S_IDLE) && rdy_en) || (last_end && !hold_last);
  assign accept_next = last_end && !hold_last && s.s_valid;
  // Back-to-back DATA keeps the same state, so the bit index restarts explicitly.
  assign restart     = (state_nxt != state) || accept_next;

  always_comb begin
    cur_bit = 1'b0;
    case (state)
      S_PRE:   cur_bit = ~bit_idx[0];
      S_SFD:   cur_bit = SFD[bit_idx[2:0]];
      S_DATA:  cur_bit = shreg[0];
`ifdef MANCH_TX_PARITY_EN
      S_PAR:   cur_bit = ^hold_data;
`endif
      default: cur_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (s.s_valid && s.s_ready) state_nxt = S_PRE;
      S_PRE:  if (bit_end && bit_idx == BW'(PREAMBLE_BITS - 1)) state_nxt = S_SFD;
      S_SFD:  if (bit_end && bit_idx == BW'(7)) state_nxt = S_DATA;
`ifdef MANCH_TX_PARITY_EN
      S_DATA: if (bit_end && bit_idx == BW'(7)) state_nxt = S_PAR;
      S_PAR:  if (bit_end) state_nxt = accept_next ? S_DATA : S_GAP;
`else
      S_DATA: if (bit_end && bit_idx == BW'(7)) state_nxt = accept_next ? S_DATA : S_GAP;
`endif
      S_GAP:  if (bit_end && bit_idx == BW'(GAP_BITS - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      phase     <= 1'b0;
      bit_idx   <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
      shreg     <= '0;
      rdy_en    <= 1'b0;
      tx_manch  <= 1'b0;
      tx_en     <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      state  <= state_nxt;

      // Timer idles at zero so every frame starts on a clean half-bit.
      if (!active) begin
        cnt   <= '0;
        phase <= 1'b0;
      end else begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        if (wrap) phase <= ~phase;
      end

      if (restart)      bit_idx <= '0;
      else if (bit_end) bit_idx <= bit_idx + 1'b1;

      if (s.s_valid && s.s_ready) begin
        hold_data <= s.s_data;
        hold_last <= s.s_last;
      end

      if (accept_next)                            shreg <= s.s_data;
      else if (state == S_SFD && state_nxt == S_DATA) shreg <= hold_data;
      else if (state == S_DATA && bit_end)        shreg <= {1'b0, shreg[7:1]};

      tx_en    <= tx_state;
      tx_manch <= tx_state && (cur_bit ^ phase);
      busy     <= active;
      underrun <= last_end && !hold_last && !s.s_valid;
    end
  end
endmodule

// File: tb/tb_manch_tx_ctrl.sv
module tb_manch_tx_ctrl;
  localparam int PB   = 8;
  localparam int HALF = 4;
  localparam logic [7:0] SFD_V = 8'hD5;
`ifdef MANCH_TX_PARITY_EN
  localparam int BPB = 9;
`else
  localparam int BPB = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_manch, tx_en, busy, underrun;
  manch_tx_ctrl_if sif();

  manch_tx_ctrl #(.CLK_FREQ(16), .BIT_RATE(2), .PREAMBLE_BITS(PB), .SFD(SFD_V), .GAP_BITS(2)) dut (
    .clk(clk), .rst(rst), .s(sif),
    .tx_manch(tx_manch), .tx_en(tx_en), .busy(busy), .underrun(underrun));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: expected line bits and tx_en lengths, pushed by the driver.
  logic exp_bits[$];
  int   exp_len[$];

  function automatic void push_frame(input logic [7:0] d0, input logic [7:0] d1, input int n);
    for (int i = 0; i < PB; i++) exp_bits.push_back(logic'(i % 2 == 0));
    for (int i = 0; i < 8; i++) exp_bits.push_back(SFD_V[i]);
    for (int b = 0; b < n; b++) begin
      logic [7:0] d;
      d = (b == 0) ? d0 : d1;
      for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef MANCH_TX_PARITY_EN
      exp_bits.push_back(^d);
`endif
    end
    exp_len.push_back((PB + 8 + n * BPB) * 2 * HALF);
  endfunction

  // Monitor: decodes the line at negedge and pops the scoreboard.
  int   run = 0, rise_cyc = 0, fall_cyc = 0, rdy_cnt = 0, urun_cnt = 0;
  logic prev_en = 1'b0, prev_busy = 1'b0, aborted = 1'b1, cur = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      exp_bits.delete(); exp_len.delete();
      run = 0; prev_en = 1'b0; prev_busy = 1'b0; aborted = 1'b1;
    end else begin
      if (tx_en) begin
        if (!prev_en) begin aborted = 1'b0; rise_cyc = cyc; end
        if (run % 8 == 0) begin
          if (exp_bits.size() == 0) begin chk("bit_queue_empty", 1, 0); cur = 1'b0; end
          else cur = exp_bits.pop_front();
        end
        if (run % 8 < 4) chk("line_half0", tx_manch, cur);
        else             chk("line_half1", tx_manch, !cur);
        run++;
        if (sif.s_ready) rdy_cnt++;
      end else begin
        if (prev_en) begin
          fall_cyc = cyc;
          if (exp_len.size() == 0) chk("len_queue_empty", 1, 0);
          else chk("txen_len", run, exp_len.pop_front());
          run = 0;
        end
        if (busy) chk("gap_line", tx_manch, 0);
      end
      if (underrun) urun_cnt++;
      if (prev_busy && !busy && !aborted) chk("busy_tail", cyc - fall_cyc, 16);
      prev_en = tx_en; prev_busy = busy;
    end
  end

  int hs_cyc = 0;
  // Called just after a negedge; returns just after the negedge following the handshake.
  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    sif.s_data = d; sif.s_last = last; sif.s_valid = 1'b1;
    while (!sif.s_ready && n < 1000) begin @(negedge clk); n++; end
    if (!sif.s_ready) chk("hs_timeout", 0, 1);
    else hs_cyc = cyc + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || tx_en) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, u0, sf, n;
    sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0;
    // Reset values
    @(posedge clk); #2;
    chk("rst_tx_en", tx_en, 0); chk("rst_tx_manch", tx_manch, 0);
    chk("rst_busy", busy, 0); chk("rst_underrun", underrun, 0);
    chk("rst_s_ready", sif.s_ready, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("ready_before_clk", sif.s_ready, 0);
    @(negedge clk);
    chk("ready_after_clk", sif.s_ready, 1);

    // Single byte
    r0 = rdy_cnt; u0 = urun_cnt;
    push_frame(8'hA5, 8'h00, 1);
    send_byte(8'hA5, 1'b1); sif.s_valid = 1'b0;
    wait_idle();
    chk("single_rdy", rdy_cnt - r0, 0); chk("single_urun", urun_cnt - u0, 0);

    // Back-to-back
    r0 = rdy_cnt; u0 = urun_cnt;
    push_frame(8'h01, 8'h80, 2);
    send_byte(8'h01, 1'b0);
    send_byte(8'h80, 1'b1); sif.s_valid = 1'b0;
    wait_idle();
    chk("b2b_rdy", rdy_cnt - r0, 1); chk("b2b_urun", urun_cnt - u0, 0);

    // Underrun
    r0 = rdy_cnt; u0 = urun_cnt;
    push_frame(8'h3C, 8'h00, 1);
    send_byte(8'h3C, 1'b0); sif.s_valid = 1'b0;
    wait_idle();
    chk("urun_rdy", rdy_cnt - r0, 1); chk("urun_pulse", urun_cnt - u0, 1);

    // Back-pressure: next byte offered during GAP
    push_frame(8'h11, 8'h00, 1);
    send_byte(8'h11, 1'b1); sif.s_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (tx_en && n < 500) begin @(negedge clk); n++; end
    chk("bp_fall_seen", tx_en, 0);
    sf = cyc;
    push_frame(8'h5A, 8'h00, 1);
    send_byte(8'h5A, 1'b1); sif.s_valid = 1'b0;
    chk("bp_hs_delay", hs_cyc - sf, 16);
    repeat (2) @(negedge clk);
    chk("bp_spacing", rise_cyc - sf, 17);
    wait_idle();

    // Reset during SFD
    u0 = urun_cnt;
    push_frame(8'h33, 8'h00, 1);
    send_byte(8'h33, 1'b1); sif.s_valid = 1'b0;
    repeat (80) @(negedge clk);
    chk("pre_rst_tx_en", tx_en, 1);
    chk("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_tx_en", tx_en, 0); chk("async_tx_manch", tx_manch, 0);
    chk("async_busy", busy, 0); chk("async_s_ready", sif.s_ready, 0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    push_frame(8'hFF, 8'h00, 1);
    send_byte(8'hFF, 1'b1); sif.s_valid = 1'b0;
    wait_idle();
    chk("rst_no_urun", urun_cnt - u0, 0);

    // Parity-bearing byte (ninth bit is 1 when parity is built)
    push_frame(8'h07, 8'h00, 1);
    send_byte(8'h07, 1'b1); sif.s_valid = 1'b0;
    wait_idle();

    chk("bits_left", exp_bits.size(), 0);
    chk("lens_left", exp_len.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
